// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter between fetch and the program loader.
package imem_arb_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DRAIN   = 2'd1,
      LOAD    = 2'd2,
      RESTART = 2'd3
   } arb_state_e;

   localparam int IMEM_AW  = 9;
   localparam int LD_CNT_W = 16;

   // Beat counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [LD_CNT_W-1:0] sat_inc(input logic [LD_CNT_W-1:0] v);
      logic [LD_CNT_W-1:0] r;
      if (v == {LD_CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + LD_CNT_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/imem_arb.sv
// Arbiter/sequencer for the single-port imem: passes fetch through, freezes and drains fetch
// for the loader, hands the port over, then restarts fetch with a one-cycle redirect.
module imem_arb
   import imem_arb_pkg::*;
#(
   parameter int AW        = IMEM_AW,
   parameter int DRAIN_CYC = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                pipe_stall,
   input  logic                pipe_jmp,
   input  logic [31:0]         pipe_jmp_pc,
   input  logic [AW-1:0]       fetch_addr,
   output logic                if_stall,
   output logic                if_jmp,
   output logic [31:0]         if_jmp_pc,
   input  logic                ld_req,
   input  logic                ld_we,
   input  logic [AW-1:0]       ld_addr,
   input  logic [31:0]         ld_wdata,
   input  logic                ld_done,
   input  logic [31:0]         ld_restart_pc,
   output logic                ld_ready,
   output logic [AW-1:0]       mem_addr,
   output logic                mem_we,
   output logic [31:0]         mem_wdata,
   output logic                busy,
   output logic [LD_CNT_W-1:0] ld_count
);

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);

   arb_state_e            state_r;
   logic [3:0]            drain_cnt_r;
   logic [31:0]           restart_pc_r;
   logic [LD_CNT_W-1:0]   ld_count_r;
   logic                  beat_s;

   assign beat_s   = ld_req & ld_we;
   assign ld_count = ld_count_r;

   // Ownership sequencing, drain countdown, beat counting and restart-PC capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= FETCH;
         drain_cnt_r  <= 4'd0;
         restart_pc_r <= 32'd0;
         ld_count_r   <= '0;
      end else begin
         case (state_r)
            FETCH: begin
               if (ld_req) begin
                  state_r     <= DRAIN;
                  drain_cnt_r <= DRAIN_INIT;
               end
            end
            DRAIN: begin
               if (drain_cnt_r == 4'd0) begin
                  state_r    <= LOAD;
                  ld_count_r <= '0;
               end else begin
                  drain_cnt_r <= drain_cnt_r - 4'd1;
               end
            end
            LOAD: begin
               // A beat coinciding with ld_done is still counted.
               if (beat_s) begin
                  ld_count_r <= sat_inc(ld_count_r);
               end
               if (ld_done) begin
                  restart_pc_r <= ld_restart_pc;
                  state_r      <= RESTART;
               end
            end
            RESTART: begin
               state_r <= FETCH;
            end
            default: begin
               state_r <= FETCH;
            end
         endcase
      end
   end

   // Output steering; if_* never depend on ld_* inputs.
   always_comb begin
      if_stall  = pipe_stall;
      if_jmp    = pipe_jmp;
      if_jmp_pc = pipe_jmp_pc;
      mem_addr  = fetch_addr;
      mem_we    = 1'b0;
      mem_wdata = ld_wdata;
      ld_ready  = 1'b0;
      busy      = 1'b1;
      case (state_r)
         FETCH: begin
            busy = 1'b0;
         end
         DRAIN: begin
            if_stall = 1'b1;
            if_jmp   = 1'b0;
         end
         LOAD: begin
            if_stall = 1'b1;
            if_jmp   = 1'b0;
            ld_ready = 1'b1;
            mem_addr = ld_addr;
            mem_we   = beat_s;
         end
         RESTART: begin
            if_stall  = 1'b0;
            if_jmp    = 1'b1;
            if_jmp_pc = restart_pc_r;
         end
         default: begin
            if_stall = 1'b1;
            if_jmp   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_arb.sv
// Self-checking bench for imem_arb: directed scenarios plus randomized traffic against a
// timestamp-based reference model of who owns the memory.
module tb_imem_arb;

   localparam int AW = 9;
   localparam int DC = 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pipe_stall = 1'b0;
   logic          pipe_jmp = 1'b0;
   logic [31:0]   pipe_jmp_pc = 32'd0;
   logic [AW-1:0] fetch_addr = '0;
   logic          if_stall;
   logic          if_jmp;
   logic [31:0]   if_jmp_pc;
   logic          ld_req = 1'b0;
   logic          ld_we = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [31:0]   ld_wdata = 32'd0;
   logic          ld_done = 1'b0;
   logic [31:0]   ld_restart_pc = 32'd0;
   logic          ld_ready;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic          busy;
   logic [15:0]   ld_count;

   imem_arb #(.AW(AW), .DRAIN_CYC(DC)) dut (
      .clk(clk), .reset_n(reset_n),
      .pipe_stall(pipe_stall), .pipe_jmp(pipe_jmp), .pipe_jmp_pc(pipe_jmp_pc),
      .fetch_addr(fetch_addr),
      .if_stall(if_stall), .if_jmp(if_jmp), .if_jmp_pc(if_jmp_pc),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_done(ld_done), .ld_restart_pc(ld_restart_pc),
      .ld_ready(ld_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .busy(busy), .ld_count(ld_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Instruction memory behind the arbiter (synchronous write port).
   logic [31:0] imem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_we) imem[mem_addr] <= mem_wdata;
   end

   // Model: edge index of the grant request and of ld_done; phases derive from elapsed edges.
   int          cyc = 0;
   int          req_edge = -1;
   int          done_edge = -1;
   logic [15:0] m_cnt = 16'd0;
   logic [31:0] m_rpc = 32'd0;

   function automatic bit m_drain();
      return (req_edge >= 0) && (cyc < req_edge + DC);
   endfunction
   function automatic bit m_load();
      return (req_edge >= 0) && (cyc >= req_edge + DC);
   endfunction
   function automatic bit m_rst();
      return (done_edge == cyc);
   endfunction

   task automatic model_reset();
      req_edge  = -1;
      done_edge = -1;
      m_cnt     = 16'd0;
      m_rpc     = 32'd0;
   endtask

   task automatic model_step();
      int nc;
      nc = cyc + 1;
      if (!reset_n) begin
         model_reset();
      end else if (m_rst()) begin
         done_edge = -1;
      end else if (m_load()) begin
         if (ld_req && ld_we && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (ld_done) begin
            done_edge = nc;
            req_edge  = -1;
            m_rpc     = ld_restart_pc;
         end
      end else if (m_drain()) begin
         if (nc == req_edge + DC) m_cnt = 16'd0;
      end else if (ld_req) begin
         req_edge = nc;
      end
      cyc = nc;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin : cmp
      bit f, l, r;
      f = !m_drain() && !m_load() && !m_rst();
      l = m_load();
      r = m_rst();
      check("if_stall", {31'd0, if_stall}, {31'd0, f ? pipe_stall : !r});
      check("if_jmp", {31'd0, if_jmp}, {31'd0, f ? pipe_jmp : r});
      if (f) check("if_jmp_pc", if_jmp_pc, pipe_jmp_pc);
      if (r) check("if_jmp_pc_rst", if_jmp_pc, m_rpc);
      check("mem_addr", {23'd0, mem_addr}, {23'd0, l ? ld_addr : fetch_addr});
      check("mem_we", {31'd0, mem_we}, {31'd0, l && ld_req && ld_we});
      check("mem_wdata", mem_wdata, ld_wdata);
      check("ld_ready", {31'd0, ld_ready}, {31'd0, l});
      check("busy", {31'd0, busy}, {31'd0, !f});
      check("ld_count", {16'd0, ld_count}, {16'd0, m_cnt});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ld();
      ld_req  = 1'b0;
      ld_we   = 1'b0;
      ld_done = 1'b0;
   endtask

   initial begin
      pipe_stall = 1'b1;
      fetch_addr = 9'h03F;
      #3;
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ld_count", {16'd0, ld_count}, 32'd0);
      #20 reset_n = 1'b1;
      tick();
      check("post_rst_if_stall", {31'd0, if_stall}, 32'd1);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_mem_addr", {23'd0, mem_addr}, 32'h03F);
      check("post_rst_mem_we", {31'd0, mem_we}, 32'd0);

      // Grant sequence and three instruction writes.
      pipe_stall = 1'b0;
      ld_req = 1'b1;
      tick();
      ld_req = 1'b0;
      check("drain_if_stall", {31'd0, if_stall}, 32'd1);
      check("drain_ld_ready", {31'd0, ld_ready}, 32'd0);
      tick();
      check("grant_ld_ready", {31'd0, ld_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         ld_req = 1'b1; ld_we = 1'b1; ld_addr = AW'(i); ld_wdata = 32'h0000_0013;
         tick();
      end
      idle_ld();
      check("load3_count", {16'd0, ld_count}, 32'd3);
      for (int i = 0; i < 3; i++) check("imem_word", imem[i], 32'h0000_0013);

      // Jump during LOAD is swallowed; restart PC wins.
      pipe_stall = 1'b1;
      pipe_jmp = 1'b1; pipe_jmp_pc = 32'h0000_0200;
      #1;
      check("load_if_jmp", {31'd0, if_jmp}, 32'd0);
      ld_done = 1'b1; ld_restart_pc = 32'h0000_0100;
      tick();
      ld_done = 1'b0; pipe_jmp = 1'b0;
      check("restart_if_jmp", {31'd0, if_jmp}, 32'd1);
      check("restart_if_jmp_pc", if_jmp_pc, 32'h0000_0100);
      check("restart_word", {23'd0, if_jmp_pc[10:2]}, 32'h040);
      check("restart_if_stall", {31'd0, if_stall}, 32'd0);
      tick();
      check("after_restart_busy", {31'd0, busy}, 32'd0);
      check("after_restart_if_jmp", {31'd0, if_jmp}, 32'd0);
      pipe_stall = 1'b0;

      // Write beat coinciding with ld_done.
      ld_req = 1'b1;
      tick();
      ld_req = 1'b0;
      tick();
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9'h005; ld_wdata = 32'hDEAD_BEEF; ld_done = 1'b1;
      #1;
      check("done_beat_we", {31'd0, mem_we}, 32'd1);
      tick();
      idle_ld();
      check("done_beat_count", {16'd0, ld_count}, 32'd1);
      check("done_beat_jmp", {31'd0, if_jmp}, 32'd1);
      check("done_beat_word", imem[5], 32'hDEAD_BEEF);
      tick();

      // Asynchronous reset in the middle of a load.
      ld_req = 1'b1;
      tick();
      tick();
      ld_we = 1'b1;
      tick();
      check("pre_rst_count", {16'd0, ld_count}, 32'd1);
      #1;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("async_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      check("async_rst_count", {16'd0, ld_count}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      idle_ld();
      tick();
      #2 reset_n = 1'b1;
      tick();

      // Long load to reach beat counter saturation.
      ld_req = 1'b1;
      tick();
      tick();
      ld_we = 1'b1;
      for (int i = 0; i < 65540; i++) begin
         ld_addr = AW'($urandom);
         ld_wdata = $urandom;
         tick();
      end
      check("sat_count", {16'd0, ld_count}, 32'h0000_FFFF);
      idle_ld();
      ld_done = 1'b1; ld_restart_pc = 32'h0000_0400;
      tick();
      idle_ld();
      tick();

      // Randomized traffic, including occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         pipe_stall    = 1'($urandom_range(0, 1));
         pipe_jmp      = ($urandom_range(0, 3) == 0);
         pipe_jmp_pc   = $urandom;
         fetch_addr    = AW'($urandom);
         ld_req        = ($urandom_range(0, 2) == 0);
         ld_we         = 1'($urandom_range(0, 1));
         ld_addr       = AW'($urandom);
         ld_wdata      = $urandom;
         ld_done       = ($urandom_range(0, 7) == 0);
         ld_restart_pc = $urandom;
         if ($urandom_range(0, 299) == 0) begin
            reset_n = 1'b0;
            model_reset();
         end else begin
            reset_n = 1'b1;
         end
         tick();
      end
      reset_n = 1'b1;
      idle_ld();
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
